// File: rtl/pipeline_reg_elastic_pkg.sv
// Constants shared by the elastic pipeline registers: datapath width and the
// instruction used as a bubble in the IF/ID register.
package pipeline_reg_elastic_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/pipeline_reg_elastic_stage.sv
// One elastic stage: a main register feeding downstream plus a skid register
// that catches the beat arriving while ready is still registered high.
module pipe_skid_stage
    import pipeline_reg_elastic_pkg::*;
#(
    parameter int               WIDTH  = XLEN,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    // valid/ready: a beat moves on a rising edge where valid and ready are both
    // high; valid never looks at ready, and data stays put until it moves.
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready_o  = ~s_valid_q;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_data_q;

    assign in_fire  = in_valid_i & ~s_valid_q;
    assign out_fire = m_valid_q & out_ready_i;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = BUBBLE;
            s_valid_d = 1'b0;
            s_data_d  = BUBBLE;
        end else if (out_fire) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
                s_data_d  = BUBBLE;
            end else if (in_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data_i;
            end else begin
                m_valid_d = 1'b0;
                m_data_d  = BUBBLE;
            end
        end else if (in_fire) begin
            // Skid only fills when main is occupied and stalled.
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data_i;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = in_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= BUBBLE;
            s_valid_q <= 1'b0;
            s_data_q  <= BUBBLE;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/pipeline_reg_elastic.sv
// Chain of DEPTH skid stages between two processor pipeline stages; holds up
// to 2*DEPTH entries and shows BUBBLE on out_data whenever nothing is valid.
module pipeline_reg_elastic
    import pipeline_reg_elastic_pkg::*;
#(
    parameter int               WIDTH  = XLEN,
    parameter int               DEPTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("pipeline_reg_elastic: DEPTH must be at least 1");
    end

    logic             ch_valid [DEPTH+1];
    logic             ch_ready [DEPTH+1];
    logic [WIDTH-1:0] ch_data  [DEPTH+1];

    assign ch_valid[0]     = in_valid;
    assign ch_data[0]      = in_data;
    assign in_ready        = ch_ready[0];
    assign ch_ready[DEPTH] = out_ready;
    assign out_valid       = ch_valid[DEPTH];
    assign out_data        = ch_valid[DEPTH] ? ch_data[DEPTH] : BUBBLE;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_skid_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .in_valid_i  (ch_valid[k]),
            .in_ready_o  (ch_ready[k]),
            .in_data_i   (ch_data[k]),
            .out_valid_o (ch_valid[k+1]),
            .out_ready_i (ch_ready[k+1]),
            .out_data_o  (ch_data[k+1])
        );
    end

endmodule

// File: tb/tb_pipeline_reg_elastic.sv
// Directed and random checks of three pipeline_reg_elastic configurations
// against queue models of the expected output stream.
module tb_pipeline_reg_elastic;
    import pipeline_reg_elastic_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // a: DEPTH=3 streaming; b: DEPTH=2 with NOP bubble; c: 8-bit DEPTH=4 random
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [31:0] a_in_data = 0, a_out_data;
    logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [31:0] b_in_data = 0, b_out_data;
    logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [7:0]  c_in_data = 0, c_out_data;

    pipeline_reg_elastic #(.WIDTH(32), .DEPTH(3), .BUBBLE(32'h0)) dut_a (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
    );

    pipeline_reg_elastic #(.WIDTH(32), .DEPTH(2), .BUBBLE(NOP_INSN)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
    );

    pipeline_reg_elastic #(.WIDTH(8), .DEPTH(4), .BUBBLE(8'h00)) dut_c (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboards: push on accepted input, pop on delivered output.
    logic [31:0] a_q[$];
    int          a_ts_q[$];
    logic [31:0] b_q[$];
    logic [7:0]  c_q[$];
    int a_out_cnt = 0, b_out_cnt = 0, c_in_cnt = 0, c_out_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            a_q.delete();
            a_ts_q.delete();
        end else begin
            if (!a_out_valid) check("a_idle_bubble", a_out_data, 32'h0);
            if (a_out_valid && a_out_ready) begin
                check("a_out_expected", 32'(a_q.size() > 0), 32'd1);
                if (a_q.size() > 0) begin
                    check("a_out_data", a_out_data, a_q.pop_front());
                    check("a_latency", 32'(cyc - a_ts_q.pop_front()), 32'd3);
                end
                a_out_cnt++;
            end
            if (a_in_valid && a_in_ready) begin
                a_q.push_back(a_in_data);
                a_ts_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst || b_flush) begin
            b_q.delete();
        end else begin
            if (!b_out_valid) check("b_idle_bubble", b_out_data, NOP_INSN);
            if (b_out_valid && b_out_ready) begin
                check("b_out_expected", 32'(b_q.size() > 0), 32'd1);
                if (b_q.size() > 0) check("b_out_data", b_out_data, b_q.pop_front());
                b_out_cnt++;
            end
            if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            c_q.delete();
        end else begin
            if (!c_out_valid) check("c_idle_bubble", 32'(c_out_data), 32'h0);
            if (c_out_valid && c_out_ready) begin
                check("c_out_expected", 32'(c_q.size() > 0), 32'd1);
                if (c_q.size() > 0) check("c_out_data", 32'(c_out_data), 32'(c_q.pop_front()));
                c_out_cnt++;
            end
            if (c_in_valid && c_in_ready) begin
                c_q.push_back(c_in_data);
                c_in_cnt++;
            end
            check("c_occupancy_le_8", 32'(c_q.size() <= 8), 32'd1);
        end
    end

    initial begin
        int   acc;
        int   base;
        logic rdy;
        logic took;

        // Reset with junk presented on every input
        a_in_valid = 1; a_in_data = 32'hDEADBEEF;
        b_in_valid = 1; b_in_data = 32'hDEADBEEF;
        c_in_valid = 1; c_in_data = 8'hEF;
        step(2);
        rst = 0;
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        step(1);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 32'h0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_out_data", b_out_data, 32'h0000_0013);
        check("rst_b_in_ready", b_in_ready, 1);
        check("rst_c_in_ready", c_in_ready, 1);

        // Streaming through DEPTH=3
        a_out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            check("a_stream_in_ready", a_in_ready, 1);
            a_in_valid = 1;
            a_in_data  = 32'(i);
            step(1);
        end
        a_in_valid = 0;
        step(8);
        check("a_stream_count", 32'(a_out_cnt), 32'd16);
        check("a_stream_left", 32'(a_q.size()), 32'd0);

        // Backpressure on DEPTH=2
        acc = 0;
        b_out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            b_in_valid = 1;
            b_in_data  = 32'h100 + 32'(acc);
            rdy = b_in_ready;
            step(1);
            if (rdy) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_in_ready_low", b_in_ready, 0);
        check("bp_out_valid", b_out_valid, 1);
        check("bp_head", b_out_data, 32'h100);
        b_in_valid = 0;
        b_out_ready = 1;
        base = b_out_cnt;
        step(2);
        check("bp_ready_back", b_in_ready, 1);
        step(4);
        check("bp_drained", 32'(b_out_cnt - base), 32'd4);
        check("bp_left", 32'(b_q.size()), 32'd0);

        // Flush a full DEPTH=2 chain
        b_out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1;
            b_in_data  = 32'h200 + 32'(i);
            step(1);
        end
        check("fl_full", b_in_ready, 0);
        b_in_data = 32'h55;
        b_flush = 1;
        step(1);
        b_flush = 0;
        b_in_valid = 0;
        check("fl_out_valid", b_out_valid, 0);
        check("fl_out_data", b_out_data, NOP_INSN);
        check("fl_in_ready", b_in_ready, 1);
        // Flush while the input is actually being accepted
        b_in_valid = 1;
        b_in_data = 32'h66;
        step(1);
        b_in_data = 32'h55;
        b_flush = 1;
        step(1);
        b_flush = 0;
        b_in_valid = 0;
        check("fl2_out_valid", b_out_valid, 0);
        b_out_ready = 1;
        base = b_out_cnt;
        step(6);
        check("fl_no_output", 32'(b_out_cnt - base), 32'd0);
        check("fl_idle_data", b_out_data, 32'h0000_0013);

        // Random traffic on the 8-bit DEPTH=4 chain
        for (int i = 0; i < 10000; i++) begin
            took = c_in_valid & c_in_ready;
            step(1);
            if (!c_in_valid || took) begin
                c_in_valid = 1'($urandom_range(0, 1));
                c_in_data  = 8'($urandom_range(0, 255));
            end
            c_out_ready = 1'($urandom_range(0, 1));
        end
        c_in_valid = 0;
        c_out_ready = 1;
        step(20);
        check("rand_left", 32'(c_q.size()), 32'd0);
        check("rand_in_eq_out", 32'(c_out_cnt), 32'(c_in_cnt));
        check("rand_some_traffic", 32'(c_in_cnt > 1000), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
